ext_bus_master: RTL and testbench

EXT_BUS_MASTER -- requirements
Module: ext_bus_master

---
 rtl/ext_bus_master.sv | 230 +++++++++++++++++++++++
 tb/tb_ext_bus_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_master.sv
// ext_bus_master: one-transaction-at-a-time master for an asynchronous
// SRAM-style external bus. Each transaction runs SETUP -> STROBE -> HOLD,
// with all phases timed by a single 8-bit down-counter. Every pin is driven
// from a flop.
//
// Ports
//   CLK, RESET      clock; synchronous active-high reset
//   REQ, WR         request and direction (1 = write); sampled only when idle
//   REQ_ADDR        14-bit transaction address
//   REQ_WDATA       16-bit write data
//   BUSY            transaction in progress
//   DONE            one-cycle completion pulse
//   TIMEOUT         valid with DONE; strobe was aborted by the READY timeout
//   RDATA           last captured read data
//   ADDR, DATA      external address bus and bidirectional data bus
//   CSn, WEn, OEn   active-low chip select, write strobe and read strobe
//   READY           target ready; only honoured when USE_READY = 1
module ext_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter bit          USE_READY   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WR,
  input  logic [13:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [15:0] RDATA,
  output logic [13:0] ADDR,
  inout  wire  [15:0] DATA,
  output logic        CSn,
  output logic        WEn,
  output logic        OEn,
  input  logic        READY
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                ext_q, ext_n;        // strobe is in its READY extension
  logic                wr_q, wr_n;
  logic                abort_q, abort_n;    // timeout seen, reported at DONE
  logic                csn_q, csn_n;
  logic                wen_q, wen_n;
  logic                oen_q, oen_n;
  logic                oe_q, oe_n;          // DATA output enable
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                timeout_q, timeout_n;
  logic                strobe_exit;
  logic                strobe_abort;

  // Next-state and next-output logic; every pin value is computed here and
  // registered below.
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    ext_n        = ext_q;
    wr_n         = wr_q;
    abort_n      = abort_q;
    csn_n        = csn_q;
    wen_n        = wen_q;
    oen_n        = oen_q;
    oe_n         = oe_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    rdata_n      = rdata_q;
    busy_n       = busy_q;
    done_n       = 1'b0;
    timeout_n    = 1'b0;
    strobe_exit  = 1'b0;
    strobe_abort = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
          ext_n   = 1'b0;
          abort_n = 1'b0;
          wr_n    = WR;
          addr_n  = REQ_ADDR;
          wdata_n = REQ_WDATA;
          oe_n    = WR;
          csn_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
          wen_n   = ~wr_q;
          oen_n   = wr_q;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      STROBE: begin
        // Minimum strobe first; then, if enabled, extend while READY is low,
        // reusing the counter for the timeout budget.
        if (!ext_q) begin
          if (cnt_q == '0) begin
            if (USE_READY && !READY) begin
              ext_n = 1'b1;
              cnt_n = TIMEOUT_LD;
            end else begin
              strobe_exit = 1'b1;
            end
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end else begin
          if (READY) begin
            strobe_exit = 1'b1;
          end else if (cnt_q == '0) begin
            strobe_exit  = 1'b1;
            strobe_abort = 1'b1;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end

        if (strobe_exit) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
          ext_n   = 1'b0;
          wen_n   = 1'b1;
          oen_n   = 1'b1;
          abort_n = strobe_abort;
          if (!wr_q && !strobe_abort) begin
            rdata_n = DATA;
          end
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          state_n   = IDLE;
          csn_n     = 1'b1;
          oe_n      = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          timeout_n = abort_q;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ext_q     <= 1'b0;
      wr_q      <= 1'b0;
      abort_q   <= 1'b0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      oen_q     <= 1'b1;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      ext_q     <= ext_n;
      wr_q      <= wr_n;
      abort_q   <= abort_n;
      csn_q     <= csn_n;
      wen_q     <= wen_n;
      oen_q     <= oen_n;
      oe_q      <= oe_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      rdata_q   <= rdata_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      timeout_q <= timeout_n;
    end
  end

  assign DATA    = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign ADDR    = addr_q;
  assign CSn     = csn_q;
  assign WEn     = wen_q;
  assign OEn     = oen_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign TIMEOUT = timeout_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_ext_bus_master.sv
// Bench for ext_bus_master: instance u0 uses default parameters (READY
// ignored), instance u1 uses USE_READY=1, TIMEOUT_CYC=10. Each transaction
// is observed pin by pin and compared with phase lengths computed from the
// timing rules.
module tb_ext_bus_master;

  localparam int SU     = 2;
  localparam int ST     = 4;
  localparam int HO     = 2;
  localparam int TO     = 10;
  localparam int BUDGET = 100;

  logic        CLK;
  logic        RESET;
  logic        req0, req1, wr, ready1;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic        tgt_en;
  logic [15:0] tgt_data;

  logic        busy0, done0, to0, csn0, wen0, oen0;
  logic        busy1, done1, to1, csn1, wen1, oen1;
  logic [15:0] rdata0, rdata1;
  logic [13:0] addr0, addr1;
  wire  [15:0] data0, data1;

  // Target model: drives read data only while its read strobe is low.
  assign data0 = (tgt_en && !oen0) ? tgt_data : 16'hzzzz;
  assign data1 = (tgt_en && !oen1) ? tgt_data : 16'hzzzz;

  ext_bus_master u0 (
    .CLK(CLK), .RESET(RESET), .REQ(req0), .WR(wr), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .BUSY(busy0), .DONE(done0), .TIMEOUT(to0),
    .RDATA(rdata0), .ADDR(addr0), .DATA(data0), .CSn(csn0), .WEn(wen0),
    .OEn(oen0), .READY(1'b0)
  );

  ext_bus_master #(.USE_READY(1'b1), .TIMEOUT_CYC(TO)) u1 (
    .CLK(CLK), .RESET(RESET), .REQ(req1), .WR(wr), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .BUSY(busy1), .DONE(done1), .TIMEOUT(to1),
    .RDATA(rdata1), .ADDR(addr1), .DATA(data1), .CSn(csn1), .WEn(wen1),
    .OEn(oen1), .READY(ready1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [15:0] rexp0, rexp1;

  typedef struct {
    int          cs_low;
    int          strobe_len;
    int          strobe_first;
    int          strobe_last;
    int          wrong_strobe;
    int          edge_bad;
    int          data_bad;
    int          addr_bad;
    int          busy_bad;
    int          done_cnt;
    int          first_csn;
    logic        to_at_done;
    logic        busy_at_done;
    logic        csn_at_done;
    logic [15:0] rdata_at_done;
  } obs_t;

  function automatic bit hiz(input logic [15:0] d);
    return $isunknown(d) || (d == 16'h0000);
  endfunction

  // Reference: strobe length and timeout from READY low for k cycles past
  // the minimum strobe.
  function automatic int exp_len(input bit use_rdy, input int k);
    if (!use_rdy) return ST;
    return (k <= TO) ? ST + k : ST + TO;
  endfunction

  function automatic bit exp_to(input bit use_rdy, input int k);
    return use_rdy && (k > TO);
  endfunction

  // Issue one request at the current negedge and observe until DONE.
  // READY (u1) is held low from the last minimum-strobe cycle for k cycles.
  // poke > 0 pulses a second REQ at that cycle while busy.
  task automatic run_txn(input bit sel, input bit w, input logic [13:0] a,
                         input logic [15:0] wd, input logic [15:0] td,
                         input int k, input int poke, output obs_t o);
    logic cs, we, oe, busy, done, tout, strobe;
    logic [15:0] d, rd;
    logic [13:0] ad;
    o = '{default: 0};
    wr = w; req_addr = a; req_wdata = wd; tgt_data = td; tgt_en = 1'b1;
    ready1 = 1'b1;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge CLK);
      if (c == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (poke > 0 && c == poke) begin
        req_addr = ~a; wr = ~w;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
      end
      if (poke > 0 && c == poke + 1) begin req0 = 1'b0; req1 = 1'b0; end
      cs = sel ? csn1 : csn0;  we = sel ? wen1 : wen0;  oe = sel ? oen1 : oen0;
      busy = sel ? busy1 : busy0;  done = sel ? done1 : done0;
      tout = sel ? to1 : to0;  d = sel ? data1 : data0;
      rd = sel ? rdata1 : rdata0;  ad = sel ? addr1 : addr0;
      if (c == 1) o.first_csn = cs;
      if (done) begin
        o.done_cnt++;
        o.to_at_done = tout; o.busy_at_done = busy; o.csn_at_done = cs;
        o.rdata_at_done = rd;
        if (!hiz(d)) o.data_bad++;
        break;
      end
      if (!cs) begin
        o.cs_low++;
        strobe = w ? !we : !oe;
        if (w ? !oe : !we) o.wrong_strobe++;
        if (strobe) begin
          o.strobe_len++;
          if (o.strobe_first == 0) o.strobe_first = o.cs_low;
          o.strobe_last = o.cs_low;
          ready1 = (o.strobe_len >= ST + k);
        end
        if (ad != a) o.addr_bad++;
        if (!busy) o.busy_bad++;
        if (w && d != wd) o.data_bad++;
        if (!w && strobe && d != td) o.data_bad++;
        if (!w && !strobe && !hiz(d)) o.data_bad++;
      end else begin
        if (!we || !oe) o.edge_bad++;
        if (!hiz(d)) o.data_bad++;
      end
    end
    ready1 = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; req0 = 1'b1; req1 = 1'b1; wr = 1'b1;
    req_addr = 14'h1555; req_wdata = 16'hBEEF;
    repeat (3) @(negedge CLK);
    checks++;
    if ({csn0, wen0, oen0, busy0, done0, to0} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctrl0: got %b want 111000", {csn0, wen0, oen0, busy0, done0, to0});
    end
    checks++;
    if ({csn1, wen1, oen1, busy1, done1, to1} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_ctrl1: got %b want 111000", {csn1, wen1, oen1, busy1, done1, to1});
    end
    checks++;
    if (addr0 !== 14'h0 || rdata0 !== 16'h0 || !hiz(data0)) begin
      errors++;
      $display("FAIL reset_bus: addr %h rdata %h data %h want 0 0 z", addr0, rdata0, data0);
    end
    req0 = 1'b0; req1 = 1'b0; RESET = 1'b0;
    rexp0 = 16'h0; rexp1 = 16'h0;
    @(negedge CLK);
  endtask

  task automatic test_write();
    obs_t o;
    logic [13:0] a;
    logic [15:0] wd;
    run_txn(0, 1'b1, 14'h0010, 16'hA5C3, 16'h0, 0, 0, o);
    checks++;
    if (o.cs_low != SU + ST + HO || o.strobe_len != ST || o.strobe_first != SU + 1) begin
      errors++;
      $display("FAIL write_timing: cs %0d we %0d first %0d want 8 4 3", o.cs_low, o.strobe_len, o.strobe_first);
    end
    checks++;
    if (o.data_bad != 0 || o.wrong_strobe != 0 || o.addr_bad != 0 || o.busy_bad != 0) begin
      errors++;
      $display("FAIL write_pins: data %0d oe %0d addr %0d busy %0d want 0", o.data_bad, o.wrong_strobe, o.addr_bad, o.busy_bad);
    end
    checks++;
    if (o.done_cnt != 1 || o.busy_at_done !== 1'b0 || o.csn_at_done !== 1'b1 || o.to_at_done !== 1'b0) begin
      errors++;
      $display("FAIL write_done: done %0d busy %b csn %b to %b want 1 0 1 0", o.done_cnt, o.busy_at_done, o.csn_at_done, o.to_at_done);
    end
    @(negedge CLK);
    checks++;
    if (done0 !== 1'b0 || addr0 !== 14'h0010) begin
      errors++;
      $display("FAIL write_after: done %b addr %h want 0 0010", done0, addr0);
    end
    for (int i = 0; i < 3; i++) begin
      a = 14'($urandom); wd = 16'($urandom) | 16'h1;
      run_txn(0, 1'b1, a, wd, 16'h0, int'($urandom_range(0, 12)), 0, o);
      checks++;
      if (o.cs_low != SU + exp_len(0, 0) + HO || o.strobe_len != exp_len(0, 0) || o.data_bad != 0 || o.done_cnt != 1) begin
        errors++;
        $display("FAIL write_rand%0d: cs %0d we %0d data %0d done %0d", i, o.cs_low, o.strobe_len, o.data_bad, o.done_cnt);
      end
    end
  endtask

  task automatic test_read();
    obs_t o;
    logic [15:0] td;
    run_txn(0, 1'b0, 14'h0021, 16'h5A5A, 16'h1234, 0, 0, o);
    rexp0 = 16'h1234;
    checks++;
    if (o.strobe_len != ST || o.wrong_strobe != 0 || o.strobe_first != SU + 1) begin
      errors++;
      $display("FAIL read_oe: oe %0d we %0d first %0d want 4 0 3", o.strobe_len, o.wrong_strobe, o.strobe_first);
    end
    checks++;
    if (o.rdata_at_done !== rexp0 || o.data_bad != 0 || o.done_cnt != 1) begin
      errors++;
      $display("FAIL read_data: rdata %h data %0d done %0d want %h 0 1", o.rdata_at_done, o.data_bad, o.done_cnt, rexp0);
    end
    for (int i = 0; i < 3; i++) begin
      td = 16'($urandom) | 16'h1;
      run_txn(0, 1'b0, 14'($urandom), 16'($urandom) | 16'h1, td, 0, 0, o);
      rexp0 = td;
      checks++;
      if (o.rdata_at_done !== rexp0 || o.strobe_len != ST || o.cs_low != SU + ST + HO) begin
        errors++;
        $display("FAIL read_rand%0d: rdata %h oe %0d cs %0d want %h 4 8", i, o.rdata_at_done, o.strobe_len, o.cs_low, rexp0);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_txn(0, 1'b1, 14'h0100, 16'hC001, 16'h0, 0, 0, o1);
    run_txn(0, 1'b0, 14'h0200, 16'h7777, 16'h4321, 0, 0, o2);
    rexp0 = 16'h4321;
    checks++;
    if (o1.done_cnt != 1 || o1.csn_at_done !== 1'b1 || o2.first_csn !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done %0d csn_done %b csn_next %b want 1 1 0", o1.done_cnt, o1.csn_at_done, o2.first_csn);
    end
    checks++;
    if (o2.cs_low != SU + ST + HO || o2.rdata_at_done !== rexp0 || o2.edge_bad != 0) begin
      errors++;
      $display("FAIL b2b_read: cs %0d rdata %h edge %0d want 8 %h 0", o2.cs_low, o2.rdata_at_done, o2.edge_bad, rexp0);
    end
  endtask

  task automatic test_ignore_req();
    obs_t o;
    int bad;
    run_txn(0, 1'b1, 14'h0ABC, 16'h1F2E, 16'h0, 0, 3, o);
    checks++;
    if (o.done_cnt != 1 || o.addr_bad != 0 || o.cs_low != SU + ST + HO || o.wrong_strobe != 0) begin
      errors++;
      $display("FAIL ignore_txn: done %0d addr %0d cs %0d oe %0d want 1 0 8 0", o.done_cnt, o.addr_bad, o.cs_low, o.wrong_strobe);
    end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (csn0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== 14'h0ABC) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_idle: %0d bad idle cycles want 0", bad);
    end
  endtask

  task automatic test_ready();
    obs_t o;
    bit w;
    int k;
    logic [15:0] td;
    run_txn(1, 1'b0, 14'h0033, 16'h1, 16'hD00D, 3, 0, o);
    rexp1 = 16'hD00D;
    checks++;
    if (o.strobe_len != 7 || o.to_at_done !== 1'b0 || o.rdata_at_done !== rexp1) begin
      errors++;
      $display("FAIL ready_ext: len %0d to %b rdata %h want 7 0 %h", o.strobe_len, o.to_at_done, o.rdata_at_done, rexp1);
    end
    run_txn(1, 1'b0, 14'h0034, 16'h1, 16'hF00F, 40, 0, o);
    checks++;
    if (o.strobe_len != 14 || o.to_at_done !== 1'b1 || o.rdata_at_done !== rexp1 || o.done_cnt != 1) begin
      errors++;
      $display("FAIL ready_timeout: len %0d to %b rdata %h done %0d want 14 1 %h 1", o.strobe_len, o.to_at_done, o.rdata_at_done, o.done_cnt, rexp1);
    end
    @(negedge CLK);
    checks++;
    if (to1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: to %b done %b want 0 0", to1, done1);
    end
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom); k = int'($urandom_range(0, 13));
      td = 16'($urandom) | 16'h1;
      run_txn(1, w, 14'($urandom), 16'($urandom) | 16'h1, td, k, 0, o);
      if (!w && !exp_to(1, k)) rexp1 = td;
      checks++;
      if (o.strobe_len != exp_len(1, k) || o.to_at_done !== exp_to(1, k) || o.cs_low != SU + exp_len(1, k) + HO
          || o.rdata_at_done !== rexp1 || o.data_bad != 0 || o.strobe_last != o.strobe_first + o.strobe_len - 1) begin
        errors++;
        $display("FAIL ready_rand%0d: w %b k %0d len %0d/%0d to %b/%b cs %0d rdata %h/%h data %0d",
                 i, w, k, o.strobe_len, exp_len(1, k), o.to_at_done, exp_to(1, k), o.cs_low, o.rdata_at_done, rexp1, o.data_bad);
      end
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    wr = 1'b1; req_addr = 14'h0777; req_wdata = 16'h9669; req0 = 1'b1;
    tgt_en = 1'b0;
    for (int c = 1; c <= SU + 2; c++) begin
      @(negedge CLK);
      req0 = 1'b0;
    end
    checks++;
    if (wen0 !== 1'b0 || csn0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: wen %b csn %b want 0 0", wen0, csn0);
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks++;
    if ({csn0, wen0, oen0, busy0, done0} !== 5'b11100 || !hiz(data0) || rdata0 !== 16'h0 || addr0 !== 14'h0) begin
      errors++;
      $display("FAIL abort_state: ctrl %b data %h rdata %h addr %h want 11100 z 0 0",
               {csn0, wen0, oen0, busy0, done0}, data0, rdata0, addr0);
    end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (done0 !== 1'b0 || csn0 !== 1'b1 || wen0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_nodone: %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    RESET = 1'b1; req0 = 1'b0; req1 = 1'b0; wr = 1'b0; ready1 = 1'b1;
    req_addr = '0; req_wdata = '0; tgt_en = 1'b0; tgt_data = '0;
    rexp0 = '0; rexp1 = '0;
    @(negedge CLK);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignore_req();
    test_ready();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
